// File: rtl/card_pkg.sv
// Shared types and constants for the card painter and the animation blocks that reuse its colour map.
package card_pkg;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam logic [5:0] BORDER_COLOR = 6'b111111;
  localparam logic [5:0] BACK_COLOR   = 6'b000011;
  localparam logic [5:0] FRONT_COLOR  = 6'b101010;

  // Marker colour per card value; ascending index order (entry 0 first).
  localparam logic [0:15][5:0] PALETTE = '{
    6'b110000, 6'b001100, 6'b110100, 6'b011100,
    6'b100011, 6'b110011, 6'b001111, 6'b111100,
    6'b010001, 6'b100100, 6'b011000, 6'b000110,
    6'b101111, 6'b010110, 6'b111001, 6'b100001
  };

endpackage

// File: rtl/card_painter_if.sv
// Scheduler-facing bundle of a card painter: start handshake, card attributes and the VGA pixel port.
interface card_painter_if #(
  parameter int COLOR_DEPTH = 6
);
  import card_pkg::*;

  logic                   go;
  logic                   face_up;
  logic [3:0]             value;
  logic [X_W-1:0]         VGA_x;
  logic [Y_W-1:0]         VGA_y;
  logic [COLOR_DEPTH-1:0] VGA_color;
  logic                   VGA_write;
  logic                   done;
  logic                   busy;

  modport master (
    output go, face_up, value,
    input  VGA_x, VGA_y, VGA_color, VGA_write, done, busy
  );

  modport slave (
    input  go, face_up, value,
    output VGA_x, VGA_y, VGA_color, VGA_write, done, busy
  );

endinterface

// File: rtl/card_pixel_color.sv
// Combinational colour of one card pixel from its in-card coordinate, face state and value.
module card_pixel_color import card_pkg::*; #(
  parameter int OBJ_W       = 40,
  parameter int OBJ_H       = 40,
  parameter int BORDER      = 2,
  parameter int MARK_W      = 16,
  parameter int COLOR_DEPTH = 6,
  parameter int XC_W        = $clog2(OBJ_W),
  parameter int YC_W        = $clog2(OBJ_H)
) (
  input  logic [XC_W-1:0]        xc,
  input  logic [YC_W-1:0]        yc,
  input  logic                   face_up,
  input  logic [3:0]             value,
  output logic [COLOR_DEPTH-1:0] color
);

  // One extra bit so the marker's exclusive upper bound fits even when it equals OBJ_W.
  localparam int XE_W = XC_W + 1;
  localparam int YE_W = YC_W + 1;

  localparam logic [XE_W-1:0] X_BLO = XE_W'(BORDER);
  localparam logic [XE_W-1:0] X_BHI = XE_W'(OBJ_W - BORDER);
  localparam logic [XE_W-1:0] X_MLO = XE_W'((OBJ_W - MARK_W) / 2);
  localparam logic [XE_W-1:0] X_MHI = XE_W'((OBJ_W + MARK_W) / 2);
  localparam logic [YE_W-1:0] Y_BLO = YE_W'(BORDER);
  localparam logic [YE_W-1:0] Y_BHI = YE_W'(OBJ_H - BORDER);
  localparam logic [YE_W-1:0] Y_MLO = YE_W'((OBJ_H - MARK_W) / 2);
  localparam logic [YE_W-1:0] Y_MHI = YE_W'((OBJ_H + MARK_W) / 2);

  logic [XE_W-1:0] xe;
  logic [YE_W-1:0] ye;
  logic            in_border;
  logic            in_mark;

  assign xe = {1'b0, xc};
  assign ye = {1'b0, yc};

  always_comb begin
    in_border = (xe < X_BLO) || (xe >= X_BHI) || (ye < Y_BLO) || (ye >= Y_BHI);
    in_mark   = (xe >= X_MLO) && (xe < X_MHI) && (ye >= Y_MLO) && (ye < Y_MHI);
    color     = COLOR_DEPTH'(FRONT_COLOR);
    if (in_border) begin
      color = COLOR_DEPTH'(BORDER_COLOR);
    end else if (!face_up) begin
      color = COLOR_DEPTH'(BACK_COLOR);
    end else if (in_mark) begin
      color = COLOR_DEPTH'(PALETTE[value]);
    end
  end

endmodule

// File: rtl/card_painter.sv
// Paints one card at a fixed screen offset, one pixel per clock, after a go pulse, then pulses done.
module card_painter import card_pkg::*; #(
  parameter int XOFFSET     = 70,
  parameter int YOFFSET     = 50,
  parameter int OBJ_W       = 40,
  parameter int OBJ_H       = 40,
  parameter int BORDER      = 2,
  parameter int MARK_W      = 16,
  parameter int COLOR_DEPTH = 6
) (
  input logic           CLOCK_50,
  input logic           Resetn,
  card_painter_if.slave bus
);

  localparam int XC_W = $clog2(OBJ_W);
  localparam int YC_W = $clog2(OBJ_H);
  localparam logic [XC_W-1:0] X_LAST = XC_W'(OBJ_W - 1);
  localparam logic [YC_W-1:0] Y_LAST = YC_W'(OBJ_H - 1);

  state_t                 state;
  logic [XC_W-1:0]        xc, nx, pix_xc;
  logic [YC_W-1:0]        yc, ny, pix_yc;
  logic                   face_q, pix_face;
  logic [3:0]             value_q, pix_value;
  logic [COLOR_DEPTH-1:0] pix_color;

  logic [X_W-1:0]         x_q;
  logic [Y_W-1:0]         y_q;
  logic [COLOR_DEPTH-1:0] color_q;
  logic                   write_q, done_q, busy_q;

  // The output registers are loaded one pixel ahead of the counters, so the colour map sees
  // the pixel about to be shown: pixel (0,0) with the live inputs on accept, else the successor.
  always_comb begin
    nx = xc + XC_W'(1);
    ny = yc;
    if (xc == X_LAST) begin
      nx = '0;
      ny = yc + YC_W'(1);
    end
    pix_xc    = nx;
    pix_yc    = ny;
    pix_face  = face_q;
    pix_value = value_q;
    if (state == IDLE) begin
      pix_xc    = '0;
      pix_yc    = '0;
      pix_face  = bus.face_up;
      pix_value = bus.value;
    end
  end

  card_pixel_color #(
    .OBJ_W      (OBJ_W),
    .OBJ_H      (OBJ_H),
    .BORDER     (BORDER),
    .MARK_W     (MARK_W),
    .COLOR_DEPTH(COLOR_DEPTH),
    .XC_W       (XC_W),
    .YC_W       (YC_W)
  ) u_color (
    .xc     (pix_xc),
    .yc     (pix_yc),
    .face_up(pix_face),
    .value  (pix_value),
    .color  (pix_color)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      state   <= IDLE;
      xc      <= '0;
      yc      <= '0;
      face_q  <= 1'b0;
      value_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.go) begin
            state   <= DRAW;
            face_q  <= bus.face_up;
            value_q <= bus.value;
            xc      <= '0;
            yc      <= '0;
            busy_q  <= 1'b1;
            write_q <= 1'b1;
            x_q     <= X_W'(XOFFSET);
            y_q     <= Y_W'(YOFFSET);
            color_q <= pix_color;
          end
        end
        DRAW: begin
          if (xc == X_LAST && yc == Y_LAST) begin
            state   <= DONE;
            write_q <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            xc      <= nx;
            yc      <= ny;
            x_q     <= X_W'(XOFFSET) + X_W'(nx);
            y_q     <= Y_W'(YOFFSET) + Y_W'(ny);
            color_q <= pix_color;
          end
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.VGA_x     = x_q;
  assign bus.VGA_y     = y_q;
  assign bus.VGA_color = color_q;
  assign bus.VGA_write = write_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_card_painter.sv
// Scoreboard bench for card_painter: each accepted card queues its expected pixels and done marker.
module tb_card_painter;

  localparam int XOFF = 70;
  localparam int YOFF = 50;
  localparam int W    = 40;
  localparam int H    = 40;
  localparam int BRD  = 2;
  localparam int MW   = 16;
  localparam int CD   = 6;
  localparam int N    = W * H;

  localparam int C_BORDER = 6'b111111;
  localparam int C_BACK   = 6'b000011;
  localparam int C_FRONT  = 6'b101010;

  typedef struct {
    bit is_done;
    int x;
    int y;
    int color;
  } exp_t;

  exp_t sb[$];

  logic CLOCK_50 = 1'b0;
  logic Resetn   = 1'b0;

  int errors      = 0;
  int checks      = 0;
  int cyc         = 0;
  int card_writes = 0;
  int accept_cyc  = 0;
  bit mon_en      = 1'b0;

  card_painter_if #(.COLOR_DEPTH(CD)) bus ();

  card_painter #(
    .XOFFSET(XOFF), .YOFFSET(YOFF), .OBJ_W(W), .OBJ_H(H),
    .BORDER(BRD), .MARK_W(MW), .COLOR_DEPTH(CD)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .Resetn  (Resetn),
    .bus     (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc++;

  function automatic int pal(int v);
    case (v)
      0: return 6'b110000;   1: return 6'b001100;   2: return 6'b110100;   3: return 6'b011100;
      4: return 6'b100011;   5: return 6'b110011;   6: return 6'b001111;   7: return 6'b111100;
      8: return 6'b010001;   9: return 6'b100100;  10: return 6'b011000;  11: return 6'b000110;
      12: return 6'b101111; 13: return 6'b010110;  14: return 6'b111001;  default: return 6'b100001;
    endcase
  endfunction

  // Reference colour straight from the card drawing rules, in card-relative pixels.
  function automatic int model_color(int cx, int cy, bit f, int v);
    if (cx < BRD || cx >= W - BRD || cy < BRD || cy >= H - BRD) return C_BORDER;
    if (!f) return C_BACK;
    if (cx >= (W - MW) / 2 && cx < (W + MW) / 2 && cy >= (H - MW) / 2 && cy < (H + MW) / 2)
      return pal(v);
    return C_FRONT;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Drives one go pulse with the DUT idle and queues the whole expected card.
  task automatic applyStimulus(input bit f, input logic [3:0] v);
    bus.go      = 1'b1;
    bus.face_up = f;
    bus.value   = v;
    tick();
    bus.go      = 1'b0;
    accept_cyc  = cyc;
    card_writes = 0;
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        sb.push_back('{1'b0, XOFF + x, YOFF + y, model_color(x, y, f, int'(v))});
    sb.push_back('{1'b1, 0, 0, 0});
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      tick();
      if (sb.size() == 0 && bus.busy == 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("wait_idle_timeout", int'(ok), 1);
  endtask

  task automatic waitWrites(input int target);
    bit ok = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge CLOCK_50);
      #1;
      if (card_writes >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("wait_writes_timeout", int'(ok), 1);
  endtask

  task automatic waitDone();
    bit ok = 1'b0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge CLOCK_50);
      #1;
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checkOutput("wait_done_timeout", int'(ok), 1);
  endtask

  task automatic pulseGo();
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_x"},     int'(bus.VGA_x), 0);
    checkOutput({tag, "_y"},     int'(bus.VGA_y), 0);
    checkOutput({tag, "_color"}, int'(bus.VGA_color), 0);
    checkOutput({tag, "_write"}, int'(bus.VGA_write), 0);
    checkOutput({tag, "_done"},  int'(bus.done), 0);
    checkOutput({tag, "_busy"},  int'(bus.busy), 0);
  endtask

  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      checkOutput("busy", int'(bus.busy), int'(sb.size() > 0));
      if (bus.VGA_write === 1'b1) begin
        card_writes++;
        if (sb.size() == 0 || sb[0].is_done) begin
          checkOutput("unexpected_write_x", int'(bus.VGA_x), -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("pix_x", int'(bus.VGA_x), e.x);
          checkOutput("pix_y", int'(bus.VGA_y), e.y);
          checkOutput("pix_color", int'(bus.VGA_color), e.color);
        end
      end
      if (bus.done === 1'b1) begin
        checkOutput("done_write_low", int'(bus.VGA_write), 0);
        if (sb.size() == 0 || !sb[0].is_done) begin
          checkOutput("unexpected_done_pending", sb.size(), 1);
        end else begin
          void'(sb.pop_front());
          checkOutput("done_latency", cyc - accept_cyc, N);
          checkOutput("card_writes", card_writes, N);
        end
        card_writes = 0;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.go      = 1'b0;
    bus.face_up = 1'b0;
    bus.value   = 4'd0;
    Resetn      = 1'b0;
    repeat (3) tick();
    checkResetOutputs("reset");
    Resetn = 1'b1;
    mon_en = 1'b1;
    tick();

    $display("[TB] face-down card");
    applyStimulus(1'b0, 4'd0);
    waitIdle();

    $display("[TB] face-up value 5, inputs changed mid-draw");
    applyStimulus(1'b1, 4'd5);
    waitWrites(700);
    bus.value   = 4'd9;
    bus.face_up = 1'b0;
    waitIdle();

    $display("[TB] go pulses during draw and on done");
    applyStimulus(1'b1, 4'd3);
    waitWrites(10);
    pulseGo();
    waitWrites(N - 1);
    pulseGo();
    waitDone();
    pulseGo();
    repeat (20) tick();
    checkOutput("no_second_card", sb.size(), 0);

    $display("[TB] reset mid-draw");
    applyStimulus(1'b1, 4'd7);
    waitWrites(100);
    Resetn = 1'b0;
    tick();
    Resetn      = 1'b1;
    sb.delete();
    card_writes = 0;
    @(negedge CLOCK_50);
    #1;
    checkResetOutputs("midreset");
    repeat (30) tick();
    applyStimulus(1'b1, 4'd12);
    waitIdle();

    $display("[TB] randomized cards");
    for (int i = 0; i < 6; i++) begin
      bit         f;
      logic [3:0] v;
      f = 1'($urandom_range(0, 1));
      v = 4'($urandom_range(0, 15));
      applyStimulus(f, v);
      waitWrites($urandom_range(1, N - 1));
      bus.value   = 4'($urandom_range(0, 15));
      bus.face_up = 1'($urandom_range(0, 1));
      pulseGo();
      waitIdle();
      repeat ($urandom_range(0, 3)) tick();
    end

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
